// File: rtl/db_addr_gen.sv
// Nested-loop SRAM read address generator for the double-buffer memory_core.
// One dimension step per db_addr_dim; the top chains carries and sums offsets.

module db_addr_dim #(
  parameter int AW = 16,
  parameter int RW = 32
) (
  input  logic          i_carry,
  input  logic [RW-1:0] i_range,
  input  logic [AW-1:0] i_stride,
  input  logic [RW-1:0] i_idx,
  input  logic [AW-1:0] i_off,
  output logic [RW-1:0] o_idx,
  output logic [AW-1:0] o_off,
  output logic          o_carry,
  output logic          o_end
);
  logic w_wrap;

  assign w_wrap = (i_idx == i_range - RW'(1));

  always_comb begin
    o_idx   = i_idx;
    o_off   = i_off;
    o_carry = 1'b0;
    if (i_carry) begin
      if (w_wrap) begin
        o_idx   = '0;
        o_off   = '0;
        o_carry = 1'b1;
      end else begin
        o_idx = i_idx + RW'(1);
        o_off = i_off + i_stride;
      end
    end
  end

  // End-of-range flag for the post-step index, so addr_last can be registered.
  assign o_end = (o_idx == i_range - RW'(1));
endmodule

module db_addr_gen #(
  parameter int NUM_DIMS = 6,
  parameter int AW       = 16,
  parameter int RW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic          start,
  input  logic [3:0]    dimensionality,
  input  logic [AW-1:0] starting_addr,
  input  logic [AW-1:0] stride_0,
  input  logic [AW-1:0] stride_1,
  input  logic [AW-1:0] stride_2,
  input  logic [AW-1:0] stride_3,
  input  logic [AW-1:0] stride_4,
  input  logic [AW-1:0] stride_5,
  input  logic [RW-1:0] range_0,
  input  logic [RW-1:0] range_1,
  input  logic [RW-1:0] range_2,
  input  logic [RW-1:0] range_3,
  input  logic [RW-1:0] range_4,
  input  logic [RW-1:0] range_5,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          addr_last,
  output logic          done,
  output logic          busy
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic [5:0][AW-1:0]          w_stride_in;
  logic [5:0][RW-1:0]          w_range_in;
  logic [NUM_DIMS-1:0][AW-1:0] w_cap_stride;
  logic [NUM_DIMS-1:0][RW-1:0] w_cap_range;
  logic                        w_cap_last;

  logic [AW-1:0]               r_base;
  logic [NUM_DIMS-1:0][AW-1:0] r_stride, r_off, w_off_nxt;
  logic [NUM_DIMS-1:0][RW-1:0] r_range, r_idx, w_idx_nxt;
  logic [NUM_DIMS:0]           w_carry;
  logic [NUM_DIMS-1:0]         w_end;

  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_valid, r_last;
  logic          w_start_ok, w_hs, w_last_hs;

  assign w_stride_in = {stride_5, stride_4, stride_3, stride_2, stride_1, stride_0};
  assign w_range_in  = {range_5, range_4, range_3, range_2, range_1, range_0};

  assign w_start_ok = start && (dimensionality != 4'd0) && (dimensionality <= 4'(NUM_DIMS));
  assign w_hs       = r_valid && addr_ready;
  // Carry out of the top dimension means every index was at its end: final beat.
  assign w_last_hs  = w_hs && w_carry[NUM_DIMS];

  // Inactive dims collapse to a single trip with no address contribution.
  always_comb begin
    w_cap_last = 1'b1;
    for (int i = 0; i < NUM_DIMS; i++) begin
      w_cap_stride[i] = '0;
      w_cap_range[i]  = RW'(1);
      if (i < int'(dimensionality)) begin
        w_cap_stride[i] = w_stride_in[i];
        w_cap_range[i]  = (w_range_in[i] == '0) ? RW'(1) : w_range_in[i];
      end
      w_cap_last = w_cap_last && (w_cap_range[i] == RW'(1));
    end
  end

  assign w_carry[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIMS; g++) begin : g_dim
      db_addr_dim #(.AW(AW), .RW(RW)) u_dim (
        .i_carry  (w_carry[g]),
        .i_range  (r_range[g]),
        .i_stride (r_stride[g]),
        .i_idx    (r_idx[g]),
        .i_off    (r_off[g]),
        .o_idx    (w_idx_nxt[g]),
        .o_off    (w_off_nxt[g]),
        .o_carry  (w_carry[g+1]),
        .o_end    (w_end[g])
      );
    end
  endgenerate

  always_comb begin
    w_addr_nxt = r_base;
    for (int i = 0; i < NUM_DIMS; i++) w_addr_nxt = w_addr_nxt + w_off_nxt[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_state <= S_IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
        S_RUN:   if (w_last_hs)  w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base   <= '0;
      r_stride <= '0;
      r_range  <= '0;
      r_idx    <= '0;
      r_off    <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        r_idx   <= '0;
        r_off   <= '0;
        r_addr  <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (r_state == S_IDLE && w_start_ok) begin
        r_base   <= starting_addr;
        r_stride <= w_cap_stride;
        r_range  <= w_cap_range;
        r_idx    <= '0;
        r_off    <= '0;
        r_addr   <= starting_addr;
        r_valid  <= 1'b1;
        r_last   <= w_cap_last;
      end else if (r_state == S_RUN && w_hs) begin
        if (w_last_hs) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_idx  <= w_idx_nxt;
          r_off  <= w_off_nxt;
          r_addr <= w_addr_nxt;
          r_last <= &w_end;
        end
      end
    end
  end

  assign addr_out   = r_addr;
  assign addr_valid = r_valid;
  assign addr_last  = r_last;
endmodule

// File: tb/tb_db_addr_gen.sv
// Randomized + directed bench for db_addr_gen against a queue-of-addresses model.

module tb_db_addr_gen;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        clk_en = 1'b1, flush = 1'b0, start = 1'b0, addr_ready = 1'b0;
  logic [3:0]  dim = 4'd0;
  logic [15:0] base = '0;
  logic [15:0] st[6];
  logic [31:0] rg[6];
  logic [15:0] addr_out;
  logic        addr_valid, addr_last, done, busy;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  db_addr_gen dut (
    .clk(clk), .reset(rst_n), .clk_en(clk_en), .flush(flush), .start(start),
    .dimensionality(dim), .starting_addr(base),
    .stride_0(st[0]), .stride_1(st[1]), .stride_2(st[2]),
    .stride_3(st[3]), .stride_4(st[4]), .stride_5(st[5]),
    .range_0(rg[0]), .range_1(rg[1]), .range_2(rg[2]),
    .range_3(rg[3]), .range_4(rg[4]), .range_5(rg[5]),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_last(addr_last), .done(done), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the full address list of a pass, computed by mixed-radix counting.
  logic [15:0] m_q[$];
  bit m_run = 0, m_done = 0, m_zero = 1;

  task automatic build();
    int unsigned total, rem, r;
    logic [15:0] a;
    total = 1;
    for (int i = 0; i < int'(dim); i++) total *= (rg[i] == 0) ? 1 : rg[i];
    m_q.delete();
    for (int unsigned k = 0; k < total; k++) begin
      rem = k;
      a   = base;
      for (int i = 0; i < int'(dim); i++) begin
        r   = (rg[i] == 0) ? 1 : rg[i];
        a   = a + 16'((rem % r) * st[i]);
        rem = rem / r;
      end
      m_q.push_back(a);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_zero = 1; m_q.delete();
    end else if (clk_en) begin
      if (flush) begin
        m_run = 0; m_done = 0; m_zero = 1; m_q.delete();
      end else if (m_done) m_done = 0;
      else if (m_run) begin
        if (addr_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_run = 0; m_done = 1; end
        end
      end else if (start && dim >= 1 && dim <= 6) begin
        build();
        m_run = 1; m_zero = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(addr_valid), 32'(m_run));
      chk("busy",  32'(busy), 32'(m_run));
      chk("done",  32'(done), 32'(m_done));
      if (m_run) begin
        chk("addr", 32'(addr_out), 32'(m_q[0]));
        chk("last", 32'(addr_last), 32'(m_q.size() == 1));
      end else begin
        chk("last_idle", 32'(addr_last), 32'd0);
        if (m_zero) chk("addr_zero", 32'(addr_out), 32'd0);
      end
    end
  end

  logic [15:0] acc_q[$];
  always @(posedge clk)
    if (rst_n && clk_en && !flush && addr_valid && addr_ready) acc_q.push_back(addr_out);

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_cfg(input int d, input logic [15:0] b,
                         input logic [15:0] s0, s1, s2, input logic [31:0] r0, r1, r2);
    dim = 4'(d); base = b;
    st[0] = s0; st[1] = s1; st[2] = s2;
    rg[0] = r0; rg[1] = r1; rg[2] = r2;
    for (int i = 3; i < 6; i++) begin st[i] = 16'($urandom); rg[i] = $urandom_range(0, 5); end
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,...; 2: random ready and clk_en
  task automatic drive(input int mode, input int c);
    case (mode)
      0: begin addr_ready = 1'b1; clk_en = 1'b1; end
      1: begin addr_ready = (c % 3 == 1); clk_en = 1'b1; end
      default: begin addr_ready = 1'($urandom); clk_en = ($urandom_range(0, 4) != 0); end
    endcase
  endtask

  task automatic finish_pass(input int mode, input string nm);
    bit ok = 0;
    for (int c = 1; c < 1500; c++) begin
      drive(mode, c);
      step();
      if (done) begin ok = 1; break; end
    end
    clk_en = 1'b1; addr_ready = 1'b0;
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL %s: done timeout", nm); end
    step();
  endtask

  task automatic kick();
    acc_q.delete();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string nm);
    addr_ready = 1'b1;
    for (int c = 0; c < 200 && acc_q.size() < n; c++) step();
    chk({nm, "_beats"}, 32'(acc_q.size()), 32'(n));
  endtask

  task automatic chk_ramp(input string nm);
    chk({nm, "_count"}, 32'(acc_q.size()), 32'd27);
    for (int i = 0; i < acc_q.size() && i < 27; i++) chk(nm, 32'(acc_q[i]), 32'(i));
  endtask

  task automatic chk_seq(input string nm, input logic [15:0] e[$]);
    chk({nm, "_count"}, 32'(acc_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < acc_q.size(); i++) chk(nm, 32'(acc_q[i]), 32'(e[i]));
  endtask

  initial begin
    logic [15:0] e[$];
    for (int i = 0; i < 6; i++) begin st[i] = '0; rg[i] = '0; end
    step(); step();
    chk("rst_valid", 32'(addr_valid), 0); chk("rst_addr", 32'(addr_out), 0);
    chk("rst_busy", 32'(busy), 0);        chk("rst_done", 32'(done), 0);
    rst_n = 1'b1; step();

    // 3x3x3 walk, first valid one cycle after start
    set_cfg(3, 16'h0000, 1, 3, 9, 3, 3, 3);
    kick();
    chk("first_valid", 32'(addr_valid), 1);
    finish_pass(0, "walk");
    chk_ramp("walk");

    kick(); finish_pass(1, "bp"); chk_ramp("bp");

    set_cfg(2, 16'hFFFE, 1, 0, 0, 4, 0, 0);
    kick(); finish_pass(0, "wrap");
    e = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}; chk_seq("wrap", e);

    set_cfg(2, 16'd4, 2, 16, 0, 2, 3, 0);
    kick(); finish_pass(1, "stride");
    e = '{16'd4, 16'd6, 16'd20, 16'd22, 16'd36, 16'd38}; chk_seq("stride", e);

    // flush after 5 beats, then restart from the base
    set_cfg(3, 16'h0000, 1, 3, 9, 3, 3, 3);
    kick(); wait_beats(5, "fl");
    flush = 1'b1; step(); flush = 1'b0; addr_ready = 1'b0;
    chk("fl_valid", 32'(addr_valid), 0); chk("fl_busy", 32'(busy), 0);
    chk("fl_addr", 32'(addr_out), 0);
    for (int i = 0; i < 3; i++) begin step(); chk("fl_nodone", 32'(done), 0); end
    kick(); finish_pass(0, "fl_re"); chk_ramp("fl_re");

    // clk_en freeze mid-pass plus an ignored start while busy
    kick(); wait_beats(10, "ce");
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("ce_addr", 32'(addr_out), 32'd10); chk("ce_valid", 32'(addr_valid), 1);
    end
    clk_en = 1'b1;
    dim = 4'd1; base = 16'h1234; start = 1'b1; step(); start = 1'b0;
    set_cfg(3, 16'h0000, 1, 3, 9, 3, 3, 3);
    finish_pass(0, "ce"); chk_ramp("ce");

    // async reset mid-pass
    kick(); wait_beats(4, "rst");
    rst_n = 1'b0; #1;
    chk("arst_valid", 32'(addr_valid), 0); chk("arst_addr", 32'(addr_out), 0);
    chk("arst_busy", 32'(busy), 0);        chk("arst_last", 32'(addr_last), 0);
    addr_ready = 1'b0; step(); step(); rst_n = 1'b1; step();

    // illegal dimensionality
    dim = 4'd0; start = 1'b1; step(); start = 1'b0; step();
    chk("dim0_busy", 32'(busy), 0);
    dim = 4'd7; start = 1'b1; step(); start = 1'b0; step();
    chk("dim7_busy", 32'(busy), 0);

    for (int p = 0; p < 40; p++) begin
      set_cfg($urandom_range(1, 6), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      kick(); finish_pass($urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
